mean_current_tracker: RTL and testbench
=======================================

# mean_current_tracker

Upstream helper for the SWIPT comms datapath. It produces the `meanCurrent` reference that the bit slicer compares live ADC samples against. On request from the comms controller (`getMeanCurrent`), it averages a power-of-two number of decimated ADC samples of the coil current. It then publishes the truncated mean, which is held until the next completed acquisition. Acquisitions abort cleanly whenever the link is not in comms mode, and a stale but valid mean is kept.

## Interface
Parameters:
- `SAMPLE_DIV`, default 100: clocks between ADC samples (1 MHz at 100 MHz clk); legal range 2..65535.
- `LOG2_N`, default 8: log2 of samples averaged (256); legal range 1..10.
- `MEAN_INIT`, default 12'h800: `meanCurrent` value after reset.

Ports:
- `clk`, in, 1: system clock.
- `nrst`, in, 1: reset, synchronous, active-low. The clock is `clk`.
- `swiptAlive`, in, 1: link active; low aborts.
- `program`, in, 2: operating program; only 2'b11 (comms) enables operation.
- `getMeanCurrent`, in, 1: request level from the comms controller; its rising edge starts an acquisition.
- `ADC`, in, 12: unsigned coil-current sample, valid every clock.
- `meanCurrent`, out, 12: last completed mean.
- `meanValid`, out, 1: one-cycle pulse when `meanCurrent` updates.
- `busy`, out, 1: high while acquiring.

## Operation
- `enable = swiptAlive && program == 2'b11`.
- Rising-edge detector: the `req_d` register samples `getMeanCurrent` every clock; `start = getMeanCurrent && !req_d`. `req_d` resets to 0, so a request held high at reset release starts an acquisition on the first enabled cycle.
- The FSM has three states: IDLE, ACQ, DONE.
- IDLE: on `start && enable`, clear the accumulator, sample counter and divider counter, then go to ACQ. Otherwise stay.
- ACQ:
  - The divider counter counts 0..`SAMPLE_DIV`-1.
  - At terminal count, it adds `ADC` (zero-extended) to the accumulator, increments the sample counter and reloads the divider to 0.
  - When the add is sample number 2^`LOG2_N`, go to DONE.
- DONE, single cycle:
  - `meanCurrent <= acc[LOG2_N +: 12]`, i.e. floor(sum / 2^`LOG2_N`) with no rounding.
  - `meanValid <= 1` for this one cycle.
  - Return to IDLE.
- Accumulator width is 12+`LOG2_N` bits. It cannot overflow: the maximum sum is 4095·2^`LOG2_N`.
- The sample counter is `LOG2_N`+1 bits wide.
- A `start` edge seen in ACQ or DONE is ignored. No queuing is done; the requester must re-raise the request.
- Abort: `enable` low in any state forces IDLE on the next edge.
  - The accumulator contents are discarded.
  - `meanCurrent` is NOT modified and `meanValid` stays 0.
  - If abort and DONE coincide, abort wins: there is no update and no pulse.
- `busy` = (state == ACQ).

## Timing
- Reset (`nrst` = 0 at a clk edge):
  - State becomes IDLE and `req_d` = 0.
  - `meanCurrent` = `MEAN_INIT`, `meanValid` = 0, `busy` = 0.
  - The accumulator and all counters are cleared.
  - Reset has priority over everything, including mid-acquisition.
- Let T be the clock edge where IDLE sees `start && enable`.
  - `busy` is high from T+1.
  - Sample k (k = 1..N, with N = 2^`LOG2_N`) captures the `ADC` value present at edge T+k·`SAMPLE_DIV`.
  - The DONE state occupies cycle T+N·`SAMPLE_DIV`.
  - `meanCurrent` and `meanValid` change at edge T+N·`SAMPLE_DIV`+1, and `busy` is low there too.
- Total latency from request edge to valid mean is N·`SAMPLE_DIV`+1 clocks. With defaults this is 25 601 clocks (256.01 µs).
- The earliest next start is the cycle after `meanValid`, provided `getMeanCurrent` has gone low and then high again.
- `meanCurrent` is glitch-free: it changes only on the `meanValid` cycle or at reset.

## Test plan
Params for all but the last test: `SAMPLE_DIV`=4, `LOG2_N`=2.
- Reset value: release `nrst` with `getMeanCurrent`=0 → `meanCurrent`=12'h800, `meanValid`=0 and `busy`=0 for 100 cycles.
- Basic average: enable, raise `getMeanCurrent` at T, drive `ADC` sequence 100, 200, 300, 403 at sample instants → `meanValid` pulses exactly at T+17 with `meanCurrent`=250 (1003/4 truncated). `busy` is high for T+1..T+16.
- Full-scale bound: `ADC`=4095 constant → `meanCurrent`=4095, with no wrap.
- Abort mid-acquisition: a prior mean of 250; drop `swiptAlive` at T+9 → `busy`=0 at T+10, no `meanValid`, `meanCurrent` stays 250. A new edge after re-enable starts a fresh average with no residue from old samples.
- Retrigger and program gating:
  - Toggle `getMeanCurrent` low/high during ACQ → ignored, one pulse at T+17.
  - `program`=2'b01 with a request edge → no acquisition.
  - Held-high request at reset release with enable → starts at the first enabled edge.
- Defaults (`SAMPLE_DIV`=100, `LOG2_N`=8), constant `ADC`=1234 → `meanValid` at T+25601 and `meanCurrent`=1234.

Source files
------------

// File: rtl/mean_current_tracker.sv
// Averages 2^LOG2_N decimated coil-current ADC samples on request and publishes
// the truncated mean as the bit-slicer reference. The operating-program input is
// named prog because "program" is a reserved word in SystemVerilog.
module mean_current_tracker #(
    parameter int          SAMPLE_DIV = 100,
    parameter int          LOG2_N     = 8,
    parameter logic [11:0] MEAN_INIT  = 12'h800
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        swiptAlive,
    input  logic [1:0]  prog,
    input  logic        getMeanCurrent,
    input  logic [11:0] ADC,
    output logic [11:0] meanCurrent,
    output logic        meanValid,
    output logic        busy
);

    localparam int ACC_W = 12 + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [15:0]      DIV_LAST = 16'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic               req_d;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [15:0]        div_r;
    logic [11:0]        mean_r;
    logic               valid_r;
    logic               busy_r;
    logic               enable_s;
    logic               start_s;

    // Qualify operation and detect the request rising edge.
    always_comb begin
        enable_s = swiptAlive && (prog == 2'b11);
        start_s  = getMeanCurrent && !req_d;
    end

    // Acquisition FSM with accumulator, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= IDLE;
            req_d   <= 1'b0;
            acc_r   <= '0;
            cnt_r   <= '0;
            div_r   <= 16'd0;
            mean_r  <= MEAN_INIT;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            req_d   <= getMeanCurrent;
            valid_r <= 1'b0;
            busy_r  <= (state_r == ACQ);
            if (!enable_s) begin
                // Abort discards the partial sum; the published mean is kept.
                state_r <= IDLE;
                acc_r   <= '0;
                cnt_r   <= '0;
                div_r   <= 16'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_s) begin
                            acc_r   <= '0;
                            cnt_r   <= '0;
                            div_r   <= 16'd0;
                            state_r <= ACQ;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    ACQ: begin
                        if (div_r == DIV_LAST) begin
                            acc_r <= acc_r + ACC_W'(ADC);
                            cnt_r <= cnt_r + CNT_W'(1);
                            div_r <= 16'd0;
                            if (cnt_r == CNT_LAST) begin
                                state_r <= DONE;
                            end else begin
                                state_r <= ACQ;
                            end
                        end else begin
                            div_r <= div_r + 16'd1;
                        end
                    end
                    DONE: begin
                        mean_r  <= acc_r[LOG2_N +: 12];
                        valid_r <= 1'b1;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign meanCurrent = mean_r;
    assign meanValid   = valid_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_mean_current_tracker.sv
// Scoreboard bench: stimulus pushes expected (edge, mean) pairs, monitors pop and
// compare whenever a DUT pulses meanValid.
module tb_mean_current_tracker;

    logic        clk = 1'b0;
    logic        nrst;
    logic        swipt_alive;
    logic [1:0]  prog;
    logic        get_mean;
    logic [11:0] adc;
    logic [11:0] mean_s, mean_d;
    logic        valid_s, valid_d, busy_s, busy_d;

    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          failures = 0;
    bit          mon_d_on = 1'b0;

    typedef struct {
        int unsigned cyc;
        logic [11:0] mean;
    } exp_t;
    exp_t q_s[$];
    exp_t q_d[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    mean_current_tracker #(.SAMPLE_DIV(4), .LOG2_N(2)) dut_s (
        .clk(clk), .nrst(nrst), .swiptAlive(swipt_alive), .prog(prog),
        .getMeanCurrent(get_mean), .ADC(adc),
        .meanCurrent(mean_s), .meanValid(valid_s), .busy(busy_s)
    );

    mean_current_tracker dut_d (
        .clk(clk), .nrst(nrst), .swiptAlive(swipt_alive), .prog(prog),
        .getMeanCurrent(get_mean), .ADC(adc),
        .meanCurrent(mean_d), .meanValid(valid_d), .busy(busy_d)
    );

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitors: each meanValid pulse must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (valid_s === 1'b1) begin
            if (q_s.size() == 0) begin
                check(1'b0, "unexpected_pulse_s", int'(edge_cnt), 0);
            end else begin
                e = q_s.pop_front();
                check(edge_cnt == e.cyc, "pulse_edge_s", int'(edge_cnt), int'(e.cyc));
                check(mean_s == e.mean, "mean_s", 32'(mean_s), 32'(e.mean));
            end
        end
        if (mon_d_on && valid_d === 1'b1) begin
            if (q_d.size() == 0) begin
                check(1'b0, "unexpected_pulse_d", int'(edge_cnt), 0);
            end else begin
                e = q_d.pop_front();
                check(edge_cnt == e.cyc, "pulse_edge_d", int'(edge_cnt), int'(e.cyc));
                check(mean_d == e.mean, "mean_d", 32'(mean_d), 32'(e.mean));
            end
        end
    end

    // One acquisition on dut_s (SAMPLE_DIV=4, N=4); optional request toggle in ACQ.
    task automatic run_acq(input logic [11:0] v [4], input logic [11:0] exp_mean, input bit toggle);
        int unsigned t0;
        bit exp_b;
        get_mean = 1'b0;
        tick();
        adc = v[0];
        get_mean = 1'b1;
        tick();
        t0 = edge_cnt;
        q_s.push_back('{cyc: t0 + 32'd17, mean: exp_mean});
        check(busy_s == 1'b0, "busy_at_T", 32'(busy_s), 0);
        for (int k = 0; k < 4; k++) begin
            adc = v[k];
            for (int j = 0; j < 4; j++) begin
                tick();
                if (toggle && edge_cnt == t0 + 32'd6) get_mean = 1'b0;
                if (toggle && edge_cnt == t0 + 32'd8) get_mean = 1'b1;
                exp_b = (edge_cnt >= t0 + 32'd1) && (edge_cnt <= t0 + 32'd16);
                check(busy_s == exp_b, "busy_acq", 32'(busy_s), 32'(exp_b));
            end
        end
        tick();
        check(busy_s == 1'b0, "busy_after_done", 32'(busy_s), 0);
        tick();
        get_mean = 1'b0;
        tick();
    endtask

    initial begin
        int unsigned t0;
        nrst = 1'b0;
        swipt_alive = 1'b1;
        prog = 2'b11;
        get_mean = 1'b0;
        adc = 12'd0;
        tick(3);
        nrst = 1'b1;

        // Reset state held for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            tick();
            check(mean_s == 12'h800 && valid_s == 1'b0 && busy_s == 1'b0,
                  "reset_state", 32'(mean_s), 32'h800);
        end
        check(mean_d == 12'h800 && busy_d == 1'b0, "reset_state_d", 32'(mean_d), 32'h800);

        // Basic average and full-scale bound.
        run_acq('{12'd100, 12'd200, 12'd300, 12'd403}, 12'd250, 1'b0);
        run_acq('{12'd4095, 12'd4095, 12'd4095, 12'd4095}, 12'd4095, 1'b0);
        run_acq('{12'd100, 12'd200, 12'd300, 12'd403}, 12'd250, 1'b0);

        // Abort mid-acquisition.
        get_mean = 1'b0;
        tick();
        adc = 12'd3000;
        get_mean = 1'b1;
        tick();
        t0 = edge_cnt;
        tick(8);
        swipt_alive = 1'b0;
        tick(2);
        check(busy_s == 1'b0, "busy_after_abort", 32'(busy_s), 0);
        tick(20);
        check(mean_s == 12'd250, "mean_kept_abort", 32'(mean_s), 250);
        swipt_alive = 1'b1;
        run_acq('{12'd8, 12'd8, 12'd8, 12'd9}, 12'd8, 1'b0);

        // Retrigger during ACQ is ignored.
        run_acq('{12'd40, 12'd40, 12'd40, 12'd43}, 12'd40, 1'b1);

        // Wrong program: request edge does nothing.
        prog = 2'b01;
        get_mean = 1'b0;
        tick();
        get_mean = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check(busy_s == 1'b0, "busy_prog01", 32'(busy_s), 0);
        end
        check(mean_s == 12'd40, "mean_kept_prog01", 32'(mean_s), 40);
        prog = 2'b11;
        get_mean = 1'b0;
        tick();

        // Request held high across reset release starts on the first edge.
        nrst = 1'b0;
        get_mean = 1'b1;
        adc = 12'd5;
        tick(3);
        nrst = 1'b1;
        tick();
        t0 = edge_cnt;
        check(mean_s == 12'h800, "mean_after_reset", 32'(mean_s), 32'h800);
        q_s.push_back('{cyc: t0 + 32'd17, mean: 12'd5});
        tick();
        check(busy_s == 1'b1, "busy_held_req", 32'(busy_s), 1);
        tick(16);
        check(busy_s == 1'b0, "busy_held_done", 32'(busy_s), 0);
        tick();
        get_mean = 1'b0;

        // Default parameters: 25601-clock latency.
        nrst = 1'b0;
        tick(3);
        nrst = 1'b1;
        adc = 12'd1234;
        tick();
        mon_d_on = 1'b1;
        get_mean = 1'b1;
        tick();
        t0 = edge_cnt;
        q_d.push_back('{cyc: t0 + 32'd25601, mean: 12'd1234});
        q_s.push_back('{cyc: t0 + 32'd17, mean: 12'd1234});
        tick(25603);
        check(mean_d == 12'd1234, "mean_d_final", 32'(mean_d), 1234);

        check(q_s.size() == 0, "pending_s", q_s.size(), 0);
        check(q_d.size() == 0, "pending_d", q_d.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
